// File: rtl/instr_fetch_regs_if.sv
// Bus between the multicycle control/datapath and the fetch state registers.
// The master drives the enables, immediate select, memory word and next PC;
// the slave (instr_fetch_regs) returns architectural state and decoded fields.
interface instr_fetch_regs_if;
  // Control/datapath -> fetch registers
  logic        irwrite;
  logic        pcwrite;
  logic [1:0]  imm_source;
  logic [31:0] mem_rdata;
  logic [31:0] result;

  // Fetch registers -> control unit / register file / datapath
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        func7_bit5;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_ext;
  logic        instr_valid;
  logic        misaligned;
  logic [31:0] retire_count;

  modport master (
    output irwrite, pcwrite, imm_source, mem_rdata, result,
    input  pc, old_pc, instr, opcode, funct3, func7_bit5, rs1, rs2, rd,
    input  imm_ext, instr_valid, misaligned, retire_count
  );

  modport slave (
    input  irwrite, pcwrite, imm_source, mem_rdata, result,
    output pc, old_pc, instr, opcode, funct3, func7_bit5, rs1, rs2, rd,
    output imm_ext, instr_valid, misaligned, retire_count
  );
endinterface

// File: rtl/instr_fetch_regs.sv
// Architectural fetch state for the multicycle core: PC, old PC, instruction
// register, sticky misaligned-target flag and retired-write counter. Decoded
// fields and the immediate are combinational from the instruction register.
module instr_fetch_regs #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  // Reset value of the retire counter; nonzero only to exercise wrap-around
  parameter logic [31:0] RETIRE_RESET = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_regs_if.slave     bus
);

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] retire_q, retire_d;

  logic        target_aligned;
  logic        pc_accept;
  logic        pc_reject;
  logic        sign;
  logic [31:0] imm;

  // Classify a PC write: only word-aligned targets are accepted
  always_comb begin
    target_aligned = (bus.result[1:0] == 2'b00);
    pc_accept      = bus.pcwrite & target_aligned;
    pc_reject      = bus.pcwrite & ~target_aligned;
  end

  // Next-state for all fetch registers; old PC captures the pre-edge PC
  always_comb begin
    pc_d         = pc_q;
    old_pc_d     = old_pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    misaligned_d = misaligned_q;
    retire_d     = retire_q;

    if (bus.irwrite) begin
      instr_d  = bus.mem_rdata;
      old_pc_d = pc_q;
      valid_d  = 1'b1;
    end

    if (pc_accept) begin
      pc_d     = bus.result;
      retire_d = retire_q + 32'd1;  // wraps modulo 2^32
    end

    if (pc_reject) begin
      misaligned_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      old_pc_q     <= RESET_PC;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      retire_q     <= RETIRE_RESET;
    end else begin
      pc_q         <= pc_d;
      old_pc_q     <= old_pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      retire_q     <= retire_d;
    end
  end

  // Sign-extended immediate, selected by format
  always_comb begin
    sign = instr_q[31];
    imm  = 32'h0000_0000;
    unique case (bus.imm_source)
      ImmI: imm = {{20{sign}}, instr_q[31:20]};
      ImmS: imm = {{20{sign}}, instr_q[31:25], instr_q[11:7]};
      ImmB: imm = {{19{sign}}, sign, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      ImmJ: imm = {{11{sign}}, sign, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

  // Drive state and decoded fields onto the bus
  always_comb begin
    bus.pc           = pc_q;
    bus.old_pc       = old_pc_q;
    bus.instr        = instr_q;
    bus.opcode       = instr_q[6:0];
    bus.funct3       = instr_q[14:12];
    bus.func7_bit5   = instr_q[30];
    bus.rs1          = instr_q[19:15];
    bus.rs2          = instr_q[24:20];
    bus.rd           = instr_q[11:7];
    bus.imm_ext      = imm;
    bus.instr_valid  = valid_q;
    bus.misaligned   = misaligned_q;
    bus.retire_count = retire_q;
  end

endmodule
